// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_e     : fetch sequencer states (local to the fetch unit)
//   OP_HALT     : HALT opcode, kept with the other controller opcodes
//   OP_*        : opcode values shared with the downstream controller
//   pc_inc()    : 8-bit program counter increment, wraps 8'hFF -> 8'h00
//   is_halt_op(): opcode comparison used by the optional halt detector
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_SETTLE = 3'd4
  } state_e;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_JUMP = 8'h02;
  localparam logic [7:0] OP_HALT = 8'hFF;

  function automatic logic [7:0] pc_inc(input logic [7:0] pc);
    return pc + 8'd1;
  endfunction

  function automatic logic is_halt_op(input logic [7:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter and pending-jump register for the fetch unit.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   jump_valid_i/addr : jump request from the controller (any cycle)
//   load_pend_i       : fetch is starting with a jump pending; take target
//   inc_i             : instruction issued this cycle; advance the PC
//   pc_o              : current program counter
//   pend_vld_o/addr_o : pending-jump flag and target
module fetch_pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       jump_valid_i,
  input  logic [7:0] jump_addr_i,
  input  logic       load_pend_i,
  input  logic       inc_i,
  output logic [7:0] pc_o,
  output logic       pend_vld_o,
  output logic [7:0] pend_addr_o
);

  logic [7:0] pc_q, pc_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_addr_q, pend_addr_d;

  always_comb begin
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;

    if (load_pend_i) begin
      pc_d       = pend_addr_q;
      pend_vld_d = 1'b0;
    end else if (inc_i) begin
      // A jump arriving with the increment wins; it is also recorded as
      // pending below, so the next fetch reloads the same target.
      pc_d = jump_valid_i ? jump_addr_i : pc_inc(pc_q);
    end

    // Set after the clear so a jump arriving as the old one is consumed
    // stays pending for the following fetch (latest wins).
    if (jump_valid_i) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = jump_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 8'h00;
    end else begin
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign pc_o        = pc_q;
  assign pend_vld_o  = pend_vld_q;
  assign pend_addr_o = pend_addr_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: reads one 16-bit word per instruction from
// a synchronous ROM, issues it to the controller, then waits SETTLE_CYCLES
// for jump/LOAD resolution before the next fetch.
// Sequence: IDLE -> FETCH (rom read) -> WAIT (capture) -> ISSUE -> SETTLE.
// Optional build macro FETCH_HALT_EN: a captured opcode of 8'hFF suppresses
// the issue, sets the sticky o_halted flag and returns to IDLE.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_run, i_hold               : fetch enable level / block new fetch start
//   o_rom_rd, o_rom_address     : ROM read strobe and address
//   i_rom_data                  : ROM data, valid the cycle after o_rom_rd
//   o_instruction_valid/_instr. : issued instruction (opcode [15:8])
//   i_jump_valid, i_jump_address: jump request, accepted in any state
//   o_pc, o_halted              : program counter, sticky halt flag
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC      = 8'h00,
  parameter int         SETTLE_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic        i_hold,
  output logic        o_rom_rd,
  output logic [7:0]  o_rom_address,
  input  logic [15:0] i_rom_data,
  output logic        o_instruction_valid,
  output logic [15:0] o_instruction,
  input  logic        i_jump_valid,
  input  logic [7:0]  i_jump_address,
  output logic [7:0]  o_pc,
  output logic        o_halted
);

  // Counter is loaded with N-1 so SETTLE lasts exactly N cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rom_rd_q, rom_rd_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        ivld_q, ivld_d;
  logic [15:0] instr_q, instr_d;
  logic        halted;

  logic        go_fetch;
  logic        load_pend;
  logic        inc_pc;
  logic [7:0]  pc;
  logic        pend_vld;
  logic [7:0]  pend_addr;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_rd_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    ivld_d     = 1'b0;
    instr_d    = 16'h0000;
    go_fetch   = 1'b0;
    load_pend  = 1'b0;
    inc_pc     = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d   = halted_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_run && !i_hold && !halted) go_fetch = 1'b1;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ROM data is valid now; capture straight into the output register
        // so the issue cycle presents it registered.
`ifdef FETCH_HALT_EN
        if (is_halt_op(i_rom_data[15:8])) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          ivld_d  = 1'b1;
          instr_d = i_rom_data;
          state_d = S_ISSUE;
        end
`else
        ivld_d  = 1'b1;
        instr_d = i_rom_data;
        state_d = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        inc_pc  = 1'b1;
        cnt_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (i_run && !i_hold) begin
          go_fetch = 1'b1;
        end else if (!i_run) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Fetch start: the read address is registered together with the state
    // change, using the pending jump target when one is waiting.
    if (go_fetch) begin
      state_d  = S_FETCH;
      rom_rd_d = 1'b1;
      if (pend_vld) begin
        load_pend  = 1'b1;
        rom_addr_d = pend_addr;
      end else begin
        rom_addr_d = pc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= 8'h00;
      ivld_q     <= 1'b0;
      instr_q    <= 16'h0000;
`ifdef FETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      ivld_q     <= ivld_d;
      instr_q    <= instr_d;
`ifdef FETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .jump_valid_i (i_jump_valid),
    .jump_addr_i  (i_jump_address),
    .load_pend_i  (load_pend),
    .inc_i        (inc_pc),
    .pc_o         (pc),
    .pend_vld_o   (pend_vld),
    .pend_addr_o  (pend_addr)
  );

  assign o_rom_rd            = rom_rd_q;
  assign o_rom_address       = rom_addr_q;
  assign o_instruction_valid = ivld_q;
  assign o_instruction       = instr_q;
  assign o_pc                = pc;
  assign o_halted            = halted;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the program counter value after reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 3, meaning the cycles waited after each issue for jump/LOAD resolution in the downstream controller (legal range 1..15).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_run, input, 1, level: fetching is enabled while high.
REQ-006 SHALL have port i_hold, input, 1, level: blocks the start of a new fetch.
REQ-007 SHALL have ports o_rom_rd (output, 1) and o_rom_address (output, 8), the instruction ROM read request and address.
REQ-008 SHALL have port i_rom_data, input, 16, the ROM read data, valid exactly one cycle after o_rom_rd.
REQ-009 SHALL have ports o_instruction_valid (output, 1) and o_instruction (output, 16), the instruction bus to the controller (opcode [15:8], operand [7:0]).
REQ-010 SHALL have ports i_jump_valid (input, 1) and i_jump_address (input, 8), the jump request from the controller.
REQ-011 SHALL have ports o_pc (output, 8), the current program counter, and o_halted (output, 1), the sticky halt flag.

Function
REQ-012 SHALL implement states S_IDLE, S_FETCH, S_WAIT, S_ISSUE and S_SETTLE; all outputs are registered.
REQ-013 SHALL leave S_IDLE for S_FETCH when i_run=1, i_hold=0 and o_halted=0, and otherwise remain in S_IDLE.
REQ-014 SHALL, in S_FETCH, drive o_rom_rd=1 for exactly one cycle with o_rom_address=o_pc, then go to S_WAIT.
REQ-015 SHALL, in S_WAIT, capture i_rom_data, then go to S_ISSUE.
REQ-016 SHALL, in S_ISSUE, drive o_instruction_valid=1 for exactly one cycle with the captured word.
REQ-017 SHALL, in S_ISSUE, set o_pc to o_pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-018 SHALL make the fetch latency from o_rom_rd to o_instruction_valid exactly 2 cycles.
REQ-019 SHALL hold o_instruction at 16'h0000 whenever o_instruction_valid=0.
REQ-020 SHALL keep S_SETTLE for SETTLE_CYCLES cycles, counted by a 4-bit down-counter.
REQ-021 SHALL, when the S_SETTLE count expires, go to S_FETCH if i_run=1 and i_hold=0, to S_IDLE if i_run=0, and otherwise stay in S_SETTLE.
REQ-022 SHALL accept i_jump_valid in any state by setting a pending-jump register to i_jump_address; a later jump overwrites an earlier one (latest wins).
REQ-023 SHALL, on entry to S_FETCH with a jump pending, load o_pc from the pending register and clear the pending flag; the read in that cycle uses the jump target.
REQ-024 SHALL give a jump in the same cycle as the S_ISSUE increment priority over the increment.
REQ-025 SHALL still issue an instruction already in S_FETCH or S_WAIT when a jump arrives, and redirect only the next fetch.
REQ-026 SHALL leave o_rom_rd=0 and o_instruction_valid=0 while in S_IDLE or S_SETTLE.

Reset
REQ-027 SHALL, on i_reset=1, set the state to S_IDLE, o_pc to RESET_PC, the pending flag and counter to 0, o_halted to 0, o_rom_rd and o_instruction_valid to 0, and o_rom_address and o_instruction to 0.
REQ-028 SHALL, on reset mid-fetch, discard in-flight ROM data, and i_reset SHALL take priority over every other input.

Configuration
REQ-029 SHALL, with macro FETCH_HALT_EN defined, check the opcode captured in S_WAIT against HALT (8'hFF).
REQ-030 SHALL, on a HALT match, suppress the issue, set o_halted=1, leave o_pc on the HALT address and go to S_IDLE, with o_halted sticky until reset.
REQ-031 SHALL, without FETCH_HALT_EN, issue 8'hFF as an ordinary instruction and tie o_halted to 0.

Structure
REQ-032 SHALL take the HALT opcode constant from the shared opcodes_def.v include alongside the existing opcodes; the state encodings are local.
REQ-033 SHALL place the program counter, pending-jump register and wrap increment in one sub-module, fetch_pc_reg.

Verification
REQ-034 SHALL verify: reset, i_run=1, ROM[0]=16'h0105 -> o_rom_rd with address 8'h00 at T, o_instruction_valid with 16'h0105 at T+2, next o_rom_rd with address 8'h01 at T+3+SETTLE_CYCLES.
REQ-035 SHALL verify: i_jump_valid with address 8'h40 during S_SETTLE -> next o_rom_address=8'h40, and o_pc=8'h41 after that issue.
REQ-036 SHALL verify: o_pc=8'hFF -> after issue o_pc=8'h00 and the next read address is 8'h00.
REQ-037 SHALL verify: i_hold=1 through S_SETTLE expiry -> no o_rom_rd until i_hold falls, then o_rom_rd on the next cycle.
REQ-038 SHALL verify: i_reset in S_WAIT -> next cycle all outputs are 0 and o_pc=RESET_PC, with no o_instruction_valid.
REQ-039 SHALL verify: FETCH_HALT_EN defined and ROM[2]=16'hFF00 -> o_halted=1, no issue of 16'hFF00, o_pc=8'h02 and no further reads despite i_run=1; without the macro, 16'hFF00 is issued.
